// File: rtl/ninjin_ddr_arbiter_if.sv
// Bundles the ninjin read/write request channels and the shared DDR burst port.
// The arbiter uses the master view; the requesters and DDR master use the slave view.
interface ninjin_ddr_arbiter_if #(
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned LWIDTH   = 12,
    parameter int unsigned LSB      = 2
);
    logic                    rd_req;
    logic [WORDSIZE-1:0]     rd_base;
    logic [LWIDTH-1:0]       rd_len;
    logic                    rd_ack;
    logic                    rd_done;
    logic                    wr_req;
    logic [WORDSIZE-1:0]     wr_base;
    logic [LWIDTH-1:0]       wr_len;
    logic                    wr_ack;
    logic                    wr_done;
    logic                    ddr_req;
    logic                    ddr_mode;
    logic [WORDSIZE+LSB-1:0] ddr_base;
    logic [LWIDTH-1:0]       ddr_len;
    logic                    ddr_done;

    modport master (
        input  rd_req, rd_base, rd_len, wr_req, wr_base, wr_len, ddr_done,
        output rd_ack, rd_done, wr_ack, wr_done, ddr_req, ddr_mode, ddr_base, ddr_len
    );

    modport slave (
        output rd_req, rd_base, rd_len, wr_req, wr_base, wr_len, ddr_done,
        input  rd_ack, rd_done, wr_ack, wr_done, ddr_req, ddr_mode, ddr_base, ddr_len
    );
endinterface

// File: rtl/ninjin_ddr_arbiter.sv
// Round-robin burst sequencer for the ninjin prefetch (read) and post (write) DDR channels.
// Define NINJIN_ARB_WPRIO_EN to give the write channel priority when both are pending.
module ninjin_ddr_arbiter #(
    parameter int unsigned WORDSIZE  = 32,
    parameter int unsigned LWIDTH    = 12,
    parameter int unsigned BURST_MAX = 256,
    parameter int unsigned LSB       = 2
) (
    input logic                   clk,
    input logic                   xrst,
    ninjin_ddr_arbiter_if.master  arb
);

    localparam logic [LWIDTH-1:0] BurstMax = LWIDTH'(BURST_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;  // 0 = read channel, 1 = write channel
    logic   last_grant_q;

    logic [1:0]          pend_q;
    logic [WORDSIZE-1:0] base_q [2];
    logic [LWIDTH-1:0]   rest_q [2];
    logic [1:0]          ack_q, done_q, zdone_q;

    logic                    ddr_mode_q;
    logic [WORDSIZE+LSB-1:0] ddr_base_q;
    logic [LWIDTH-1:0]       ddr_len_q;

    logic [1:0]          req;
    logic [WORDSIZE-1:0] req_base [2];
    logic [LWIDTH-1:0]   req_len  [2];
    logic                start;

    assign req         = {arb.wr_req, arb.rd_req};
    assign req_base[0] = arb.rd_base;
    assign req_base[1] = arb.wr_base;
    assign req_len[0]  = arb.rd_len;
    assign req_len[1]  = arb.wr_len;
    assign start       = (state_q == StIdle) && (state_d == StIssue);

    // State register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (start) last_grant_q <= grant_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    state_d = StIssue;
                    if (pend_q == 2'b11) begin
`ifdef NINJIN_ARB_WPRIO_EN
                        grant_d = 1'b1;
`else
                        grant_d = ~last_grant_q;
`endif
                    end else begin
                        grant_d = pend_q[1];
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (arb.ddr_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        arb.ddr_req = (state_q == StIssue);
    end

    assign arb.ddr_mode = ddr_mode_q;
    assign arb.ddr_base = ddr_base_q;
    assign arb.ddr_len  = ddr_len_q;
    assign arb.rd_ack   = ack_q[0];
    assign arb.wr_ack   = ack_q[1];
    assign arb.rd_done  = done_q[0];
    assign arb.wr_done  = done_q[1];

    // Per-channel transfer bookkeeping and burst command registers
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            pend_q     <= '0;
            base_q[0]  <= '0;
            base_q[1]  <= '0;
            rest_q[0]  <= '0;
            rest_q[1]  <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            zdone_q    <= '0;
            ddr_mode_q <= 1'b0;
            ddr_base_q <= '0;
            ddr_len_q  <= '0;
        end else begin
            ack_q   <= '0;
            done_q  <= zdone_q;
            zdone_q <= '0;

            if (start) begin
                ddr_mode_q <= grant_d;
                ddr_base_q <= (WORDSIZE+LSB)'(base_q[grant_d]) << LSB;
                ddr_len_q  <= (rest_q[grant_d] > BurstMax) ? BurstMax : rest_q[grant_d];
            end

            if (state_q == StWait && arb.ddr_done) begin
                base_q[grant_q] <= base_q[grant_q] + WORDSIZE'(ddr_len_q);
                rest_q[grant_q] <= rest_q[grant_q] - ddr_len_q;
                if (rest_q[grant_q] == ddr_len_q) begin
                    pend_q[grant_q] <= 1'b0;
                    done_q[grant_q] <= 1'b1;
                end
            end

            // A channel only accepts while idle, so this never collides with its own burst update
            for (int c = 0; c < 2; c++) begin
                if (req[c] && !pend_q[c]) begin
                    base_q[c] <= req_base[c];
                    rest_q[c] <= req_len[c];
                    ack_q[c]  <= 1'b1;
                    if (req_len[c] != '0) pend_q[c]  <= 1'b1;
                    else                  zdone_q[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ninjin_ddr_arbiter.sv
// Self-checking bench for ninjin_ddr_arbiter: directed and randomized transfers against a
// burst-list reference model; honours NINJIN_ARB_WPRIO_EN for the expected grant order.
module tb_ninjin_ddr_arbiter;

    logic clk  = 1'b0;
    logic xrst = 1'b0;

    ninjin_ddr_arbiter_if #(.WORDSIZE(32), .LWIDTH(12), .LSB(2)) bus ();

    ninjin_ddr_arbiter #(
        .WORDSIZE (32),
        .LWIDTH   (12),
        .BURST_MAX(256),
        .LSB      (2)
    ) dut (
        .clk (clk),
        .xrst(xrst),
        .arb (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mode;
        logic [33:0] base;
        logic [11:0] len;
    } burst_t;

    int     total = 0;
    int     bad   = 0;
    burst_t exp_q[$];
    int     r_left, w_left;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {12'd0, bus.rd_ack, bus.rd_done, bus.wr_ack, bus.wr_done, bus.ddr_req,
                bus.ddr_mode, bus.ddr_base, bus.ddr_len};
    endfunction

    // Chop one transfer into bursts of at most 256 words
    function automatic void chop(input bit mode, input logic [31:0] base, input int len,
                                 inout burst_t q[$]);
        logic [31:0] b = base;
        int rest = len;
        while (rest > 0) begin
            int l = (rest > 256) ? 256 : rest;
            burst_t e;
            e.mode = mode;
            e.base = {b, 2'b00};
            e.len  = 12'(l);
            q.push_back(e);
            b    = b + 32'(l);
            rest = rest - l;
        end
    endfunction

    // Expected issue order when both transfers arrive together right after reset
    function automatic void build(input bit en_r, input logic [31:0] rb, input int rl,
                                  input bit en_w, input logic [31:0] wb, input int wl);
        burst_t rq[$];
        burst_t wq[$];
        bit last = 1'b1;
        exp_q.delete();
        if (en_r) chop(1'b0, rb, rl, rq);
        if (en_w) chop(1'b1, wb, wl, wq);
        r_left = rq.size();
        w_left = wq.size();
        while (rq.size() != 0 || wq.size() != 0) begin
            bit g;
            if (rq.size() != 0 && wq.size() != 0) begin
`ifdef NINJIN_ARB_WPRIO_EN
                g = 1'b1;
`else
                g = ~last;
`endif
            end else begin
                g = (wq.size() != 0);
            end
            last = g;
            if (g) exp_q.push_back(wq.pop_front());
            else   exp_q.push_back(rq.pop_front());
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        xrst         = 1'b0;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        bus.ddr_done = 1'b0;
        #1;
        check("reset_outs", all_outs(), 64'd0);
        @(negedge clk);
        xrst = 1'b1;
    endtask

    task automatic run_pair(input bit en_r, input logic [31:0] rb, input int rl,
                            input bit en_w, input logic [31:0] wb, input int wl,
                            input bit dup);
        int     cyc, last_req, cd, r_due, w_due;
        bit     in_flight;
        burst_t cur;
        build(en_r, rb, rl, en_w, wb, wl);
        @(negedge clk);
        bus.rd_req  = en_r;
        bus.rd_base = rb;
        bus.rd_len  = 12'(rl);
        bus.wr_req  = en_w;
        bus.wr_base = wb;
        bus.wr_len  = 12'(wl);
        r_due     = (en_r && rl == 0) ? 2 : -1;
        w_due     = (en_w && wl == 0) ? 2 : -1;
        last_req  = -10;
        in_flight = 1'b0;
        cd        = 0;
        for (cyc = 1; ; cyc++) begin
            @(negedge clk);
            check("rd_ack", bus.rd_ack, (cyc == 1) && en_r);
            check("wr_ack", bus.wr_ack, (cyc == 1) && en_w);
            check("rd_done", bus.rd_done, cyc == r_due);
            check("wr_done", bus.wr_done, cyc == w_due);
            bus.rd_req   = 1'b0;
            bus.wr_req   = 1'b0;
            bus.ddr_done = 1'b0;
            if (dup && cyc == 2) begin
                bus.rd_req  = 1'b1;
                bus.rd_base = ~rb;
                bus.rd_len  = 12'd5;
            end
            if (in_flight) begin
                cd--;
                if (cd == 0) begin
                    bus.ddr_done = 1'b1;
                    in_flight    = 1'b0;
                    check("hold_base", bus.ddr_base, cur.base);
                    check("hold_len", bus.ddr_len, cur.len);
                    if (cur.mode) begin
                        w_left--;
                        if (w_left == 0) w_due = cyc + 1;
                    end else begin
                        r_left--;
                        if (r_left == 0) r_due = cyc + 1;
                    end
                end
            end
            if (bus.ddr_req) begin
                check("extra_burst", exp_q.size() == 0, 1'b0);
                check("req_spacing", (cyc - last_req) >= 3, 1'b1);
                last_req = cyc;
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("ddr_mode", bus.ddr_mode, cur.mode);
                    check("ddr_base", bus.ddr_base, cur.base);
                    check("ddr_len", bus.ddr_len, cur.len);
                    in_flight = 1'b1;
                    cd        = $urandom_range(1, 3);
                end
            end
            if (exp_q.size() == 0 && !in_flight && cyc > r_due && cyc > w_due && cyc > 3) break;
            if (cyc >= 2000) begin
                check("timeout", exp_q.size(), 0);
                break;
            end
        end
        bus.ddr_done = 1'b0;
    endtask

    initial begin
        bus.rd_req   = 1'b0;
        bus.rd_base  = '0;
        bus.rd_len   = '0;
        bus.wr_req   = 1'b0;
        bus.wr_base  = '0;
        bus.wr_len   = '0;
        bus.ddr_done = 1'b0;

        // Read of 600 words split 256/256/88, with an ignored duplicate request
        do_reset();
        run_pair(1'b1, 32'h2800, 600, 1'b0, 32'h0, 0, 1'b1);

        // Simultaneous read and write
        do_reset();
        run_pair(1'b1, 32'h0, 300, 1'b1, 32'h100, 64, 1'b0);

        // Zero-length read
        do_reset();
        run_pair(1'b1, 32'h1234, 0, 1'b0, 32'h0, 0, 1'b0);

        // Address wrap on both channels
        do_reset();
        run_pair(1'b1, 32'hffff_ff80, 600, 1'b1, 32'hffff_fff0, 300, 1'b0);

        // Reset while a 512-word read is waiting for its first burst to finish
        do_reset();
        begin
            bit seen = 1'b0;
            @(negedge clk);
            bus.rd_req  = 1'b1;
            bus.rd_base = 32'h4000;
            bus.rd_len  = 12'd512;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                bus.rd_req = 1'b0;
                seen = bus.ddr_req;
            end
            check("mid_issue_seen", seen, 1'b1);
            @(negedge clk);
            xrst = 1'b0;
            #1;
            check("mid_reset_outs", all_outs(), 64'd0);
            @(negedge clk);
            bus.ddr_done = 1'b1;
            @(negedge clk);
            xrst = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                bus.ddr_done = 1'b0;
                check("post_reset_quiet", {bus.ddr_req, bus.rd_ack, bus.rd_done,
                                           bus.wr_ack, bus.wr_done}, 5'd0);
            end
            run_pair(1'b0, 32'h0, 0, 1'b1, 32'h0bad_c0de, 8, 1'b0);
        end

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            bit          er, ew;
            logic [31:0] rb, wb;
            int          rl, wl;
            er = ($urandom_range(0, 3) != 0);
            ew = ($urandom_range(0, 3) != 0);
            rb = $urandom;
            wb = $urandom;
            rl = (t % 4 == 3) ? 0 : $urandom_range(1, 900);
            wl = $urandom_range(0, 900);
            do_reset();
            run_pair(er, rb, rl, ew, wb, wl, er && rl != 0 && t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
